// File: rtl/gbf_ctrl_pkg.sv
// ============================================================================
// Module  : gbf_ctrl_pkg
// Purpose : Bank-state encodings and pointer-advance helper for the GBF ctrl.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package gbf_ctrl_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'b00,
    BANK_FILLING = 2'b01,
    BANK_FULL    = 2'b10
  } bank_state_t;

  function automatic logic [31:0] ptr_advance(input logic [31:0] ptr, input logic [31:0] num);
    return (ptr == num - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gbf_bank_mem.sv
// ============================================================================
// Module  : gbf_bank_mem
// Purpose : One buffer bank; synchronous write, registered 1-cycle read.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module gbf_bank_mem #(
  parameter int DATA_BITWIDTH = 256,
  parameter int ADDR_BITWIDTH = 5,
  parameter int DEPTH         = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [ADDR_BITWIDTH-1:0] wr_addr,
  input  logic [DATA_BITWIDTH-1:0] wr_data,
  input  logic                     rd_en,
  input  logic [ADDR_BITWIDTH-1:0] rd_addr,
  output logic [DATA_BITWIDTH-1:0] rd_data
);

  logic [DATA_BITWIDTH-1:0] r_mem [DEPTH];
  logic [DATA_BITWIDTH-1:0] w_rd_word;

  // Addresses beyond DEPTH return zero instead of indexing past the array.
  assign w_rd_word = (32'(rd_addr) < 32'(DEPTH)) ? r_mem[rd_addr] : '0;

  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= w_rd_word;
  end

endmodule

`default_nettype wire

// File: rtl/multi_bank_gbf_ctrl.sv
// ============================================================================
// Module  : multi_bank_gbf_ctrl
// Purpose : N-bank round-robin global buffer controller with per-bank reuse.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module multi_bank_gbf_ctrl
  import gbf_ctrl_pkg::*;
#(
  parameter int NUM_BANK       = 2,
  parameter int BANK_BITWIDTH  = 1,
  parameter int DATA_BITWIDTH  = 256,
  parameter int ADDR_BITWIDTH  = 5,
  parameter int DEPTH          = 32,
  parameter int FILL_LEN       = 32,
  parameter int REUSE_BITWIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic [NUM_BANK-1:0]       need_data,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [DATA_BITWIDTH-1:0]  wr_data,
  output logic [BANK_BITWIDTH-1:0]  wr_bank,
  input  logic [REUSE_BITWIDTH-1:0] cfg_reuse,
  input  logic                      rd_en,
  input  logic [ADDR_BITWIDTH-1:0]  rd_addr,
  input  logic                      rd_last,
  output logic                      rd_ready,
  output logic [BANK_BITWIDTH-1:0]  rd_bank,
  output logic [DATA_BITWIDTH-1:0]  rd_data,
  output logic                      rd_valid,
  output logic                      err_oob
);

  localparam logic [31:0] c_FILL_LAST = 32'(FILL_LEN - 1);

  bank_state_t               r_state    [NUM_BANK];
  logic [REUSE_BITWIDTH-1:0] r_pass_cnt [NUM_BANK];
  logic [REUSE_BITWIDTH-1:0] r_reuse_q  [NUM_BANK];
  logic [BANK_BITWIDTH-1:0]  r_fill_ptr, r_rd_ptr, r_rd_sel;
  logic [ADDR_BITWIDTH-1:0]  r_fill_cnt;
  logic                      r_rd_valid, r_err_oob;

  logic                      w_wr_acc, w_rd_acc, w_fill_done, w_release, w_oob;
  logic [REUSE_BITWIDTH-1:0] w_reuse;
  logic [DATA_BITWIDTH-1:0]  w_bank_rd [NUM_BANK];

  assign wr_ready    = (r_state[r_fill_ptr] != BANK_FULL);
  assign rd_ready    = (r_state[r_rd_ptr] == BANK_FULL);
  assign wr_bank     = r_fill_ptr;
  assign rd_bank     = r_rd_ptr;
  assign rd_valid    = r_rd_valid;
  assign err_oob     = r_err_oob;
  assign rd_data     = w_bank_rd[r_rd_sel];

  assign w_wr_acc    = wr_valid && wr_ready;
  assign w_rd_acc    = rd_en && rd_ready;
  assign w_fill_done = w_wr_acc && (32'(r_fill_cnt) == c_FILL_LAST);
  assign w_release   = w_rd_acc && rd_last &&
                       (r_pass_cnt[r_rd_ptr] == r_reuse_q[r_rd_ptr] - REUSE_BITWIDTH'(1));
  assign w_oob       = (32'(rd_addr) >= 32'(FILL_LEN));
  assign w_reuse     = (cfg_reuse == '0) ? REUSE_BITWIDTH'(1) : cfg_reuse;

  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    assign need_data[b] = (r_state[b] == BANK_EMPTY);

    gbf_bank_mem #(
      .DATA_BITWIDTH (DATA_BITWIDTH),
      .ADDR_BITWIDTH (ADDR_BITWIDTH),
      .DEPTH         (DEPTH)
    ) u_mem (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (w_wr_acc && (r_fill_ptr == BANK_BITWIDTH'(b))),
      .wr_addr (r_fill_cnt),
      .wr_data (wr_data),
      .rd_en   (w_rd_acc && (r_rd_ptr == BANK_BITWIDTH'(b))),
      .rd_addr (rd_addr),
      .rd_data (w_bank_rd[b])
    );
  end

  // Fill completion and release always hit different banks (FULL vs not FULL),
  // so both state updates can land in the same cycle without conflict.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < NUM_BANK; b++) begin
        r_state[b]    <= BANK_EMPTY;
        r_pass_cnt[b] <= '0;
        r_reuse_q[b]  <= '0;
      end
      r_fill_ptr <= '0;
      r_rd_ptr   <= '0;
      r_rd_sel   <= '0;
      r_fill_cnt <= '0;
      r_rd_valid <= 1'b0;
      r_err_oob  <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        if (w_fill_done) begin
          r_state[r_fill_ptr]   <= BANK_FULL;
          r_reuse_q[r_fill_ptr] <= w_reuse;
          r_fill_cnt            <= '0;
          r_fill_ptr            <= BANK_BITWIDTH'(ptr_advance(32'(r_fill_ptr), 32'(NUM_BANK)));
        end else begin
          r_state[r_fill_ptr] <= BANK_FILLING;
          r_fill_cnt          <= r_fill_cnt + ADDR_BITWIDTH'(1);
        end
      end
      if (w_rd_acc && rd_last) begin
        if (w_release) begin
          r_state[r_rd_ptr]    <= BANK_EMPTY;
          r_pass_cnt[r_rd_ptr] <= '0;
          r_rd_ptr             <= BANK_BITWIDTH'(ptr_advance(32'(r_rd_ptr), 32'(NUM_BANK)));
        end else begin
          r_pass_cnt[r_rd_ptr] <= r_pass_cnt[r_rd_ptr] + REUSE_BITWIDTH'(1);
        end
      end
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc)          r_rd_sel  <= r_rd_ptr;
      if (w_rd_acc && w_oob) r_err_oob <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multi_bank_gbf_ctrl.sv
// ============================================================================
// Module  : tb_multi_bank_gbf_ctrl
// Purpose : Directed self-checking bench for multi_bank_gbf_ctrl.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multi_bank_gbf_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // DUT A: FILL_LEN = DEPTH = 4
  logic [1:0] a_need, a_wr_bank_o, a_rd_bank_o;
  logic       a_wr_valid, a_wr_ready, a_rd_en, a_rd_last, a_rd_ready, a_rd_valid, a_err;
  logic [7:0] a_wr_data, a_reuse, a_rd_data;
  logic [1:0] a_rd_addr;
  logic [0:0] a_wr_bank, a_rd_bank;

  // DUT B: FILL_LEN = 3, DEPTH = 4
  logic [1:0] b_need;
  logic       b_wr_valid, b_wr_ready, b_rd_en, b_rd_last, b_rd_ready, b_rd_valid, b_err;
  logic [7:0] b_wr_data, b_reuse, b_rd_data;
  logic [1:0] b_rd_addr;
  logic [0:0] b_wr_bank, b_rd_bank;

  multi_bank_gbf_ctrl #(
    .NUM_BANK(2), .BANK_BITWIDTH(1), .DATA_BITWIDTH(8), .ADDR_BITWIDTH(2),
    .DEPTH(4), .FILL_LEN(4), .REUSE_BITWIDTH(8)
  ) u_dut_a (
    .clk(clk), .reset(reset), .need_data(a_need),
    .wr_valid(a_wr_valid), .wr_ready(a_wr_ready), .wr_data(a_wr_data), .wr_bank(a_wr_bank),
    .cfg_reuse(a_reuse), .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_last(a_rd_last),
    .rd_ready(a_rd_ready), .rd_bank(a_rd_bank), .rd_data(a_rd_data),
    .rd_valid(a_rd_valid), .err_oob(a_err)
  );

  multi_bank_gbf_ctrl #(
    .NUM_BANK(2), .BANK_BITWIDTH(1), .DATA_BITWIDTH(8), .ADDR_BITWIDTH(2),
    .DEPTH(4), .FILL_LEN(3), .REUSE_BITWIDTH(8)
  ) u_dut_b (
    .clk(clk), .reset(reset), .need_data(b_need),
    .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .wr_data(b_wr_data), .wr_bank(b_wr_bank),
    .cfg_reuse(b_reuse), .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_last(b_rd_last),
    .rd_ready(b_rd_ready), .rd_bank(b_rd_bank), .rd_data(b_rd_data),
    .rd_valid(b_rd_valid), .err_oob(b_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_write(input logic [7:0] d);
    a_wr_valid = 1'b1; a_wr_data = d;
    tick();
    a_wr_valid = 1'b0;
  endtask

  task automatic a_read(input logic [1:0] addr, input logic last);
    a_rd_en = 1'b1; a_rd_addr = addr; a_rd_last = last;
    tick();
    a_rd_en = 1'b0; a_rd_last = 1'b0;
  endtask

  task automatic b_write(input logic [7:0] d);
    b_wr_valid = 1'b1; b_wr_data = d;
    tick();
    b_wr_valid = 1'b0;
  endtask

  task automatic b_read(input logic [1:0] addr);
    b_rd_en = 1'b1; b_rd_addr = addr; b_rd_last = 1'b0;
    tick();
    b_rd_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    a_wr_valid = 0; a_wr_data = 0; a_reuse = 8'd1; a_rd_en = 0; a_rd_addr = 0; a_rd_last = 0;
    b_wr_valid = 0; b_wr_data = 0; b_reuse = 8'd1; b_rd_en = 0; b_rd_addr = 0; b_rd_last = 0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset / idle state
    chk("rst_need",     32'(a_need),     32'h3);
    chk("rst_wr_ready", 32'(a_wr_ready), 32'h1);
    chk("rst_rd_ready", 32'(a_rd_ready), 32'h0);
    chk("rst_rd_valid", 32'(a_rd_valid), 32'h0);
    chk("rst_err",      32'(a_err),      32'h0);
    chk("rst_rd_data",  32'(a_rd_data),  32'h0);
    chk("rst_wr_bank",  32'(a_wr_bank),  32'h0);
    chk("rst_rd_bank",  32'(a_rd_bank),  32'h0);

    // Fill bank0, reuse 1
    a_reuse = 8'd1;
    for (int i = 0; i < 4; i++) a_write(8'hA0 + 8'(i));
    chk("fill0_need",     32'(a_need),     32'h2);
    chk("fill0_wr_bank",  32'(a_wr_bank),  32'h1);
    chk("fill0_rd_ready", 32'(a_rd_ready), 32'h1);
    a_read(2'd2, 1'b0);
    chk("rd2_valid", 32'(a_rd_valid), 32'h1);
    chk("rd2_data",  32'(a_rd_data),  32'hA2);
    tick();
    chk("rd2_valid_drop", 32'(a_rd_valid), 32'h0);
    chk("rd2_data_hold",  32'(a_rd_data),  32'hA2);

    // Fill bank1, then both full: writes blocked
    for (int i = 0; i < 4; i++) a_write(8'hB0 + 8'(i));
    chk("full_need",     32'(a_need),     32'h0);
    chk("full_wr_ready", 32'(a_wr_ready), 32'h0);
    a_wr_valid = 1'b1; a_wr_data = 8'hEE;
    tick(); tick();
    a_wr_valid = 1'b0;
    chk("blocked_wr_bank", 32'(a_wr_bank), 32'h0);
    chk("blocked_need",    32'(a_need),    32'h0);

    // Release bank0 (data must still be A0, not EE)
    a_read(2'd0, 1'b1);
    chk("rel0_data",     32'(a_rd_data),  32'hA0);
    chk("rel0_need",     32'(a_need),     32'h1);
    chk("rel0_rd_bank",  32'(a_rd_bank),  32'h1);
    chk("rel0_wr_ready", 32'(a_wr_ready), 32'h1);
    chk("rel0_rd_ready", 32'(a_rd_ready), 32'h1);
    a_read(2'd3, 1'b0);
    chk("b1_rd3_data", 32'(a_rd_data), 32'hB3);

    // Refill bank0 with reuse 3, then release bank1
    a_reuse = 8'd3;
    for (int i = 0; i < 4; i++) a_write(8'hC0 + 8'(i));
    chk("fill0b_wr_bank", 32'(a_wr_bank), 32'h1);
    a_read(2'd1, 1'b1);
    chk("rel1_data",    32'(a_rd_data), 32'hB1);
    chk("rel1_rd_bank", 32'(a_rd_bank), 32'h0);
    chk("rel1_need",    32'(a_need),    32'h2);

    // Three passes over bank0
    a_read(2'd1, 1'b1);
    chk("pass1_data",    32'(a_rd_data), 32'hC1);
    chk("pass1_rd_bank", 32'(a_rd_bank), 32'h0);
    chk("pass1_need",    32'(a_need),    32'h2);
    a_read(2'd2, 1'b1);
    chk("pass2_data",    32'(a_rd_data),  32'hC2);
    chk("pass2_rd_bank", 32'(a_rd_bank),  32'h0);
    chk("pass2_ready",   32'(a_rd_ready), 32'h1);
    a_read(2'd3, 1'b1);
    chk("pass3_data",    32'(a_rd_data),  32'hC3);
    chk("pass3_rd_bank", 32'(a_rd_bank),  32'h1);
    chk("pass3_need",    32'(a_need),     32'h3);
    chk("pass3_ready",   32'(a_rd_ready), 32'h0);

    // Read while nothing is full is ignored
    a_read(2'd0, 1'b1);
    chk("ign_valid",   32'(a_rd_valid), 32'h0);
    chk("ign_data",    32'(a_rd_data),  32'hC3);
    chk("ign_need",    32'(a_need),     32'h3);
    chk("ign_rd_bank", 32'(a_rd_bank),  32'h1);
    chk("ign_err",     32'(a_err),      32'h0);

    // Half-done fill on bank1, then reset
    a_reuse = 8'd1;
    a_write(8'hD0); a_write(8'hD1);
    chk("half_need",    32'(a_need),    32'h1);
    chk("half_wr_bank", 32'(a_wr_bank), 32'h1);
    reset = 1'b1;
    #1;
    chk("arst_need",     32'(a_need),     32'h3);
    chk("arst_wr_bank",  32'(a_wr_bank),  32'h0);
    chk("arst_rd_bank",  32'(a_rd_bank),  32'h0);
    chk("arst_rd_data",  32'(a_rd_data),  32'h0);
    chk("arst_wr_ready", 32'(a_wr_ready), 32'h1);
    tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) a_write(8'hE0 + 8'(i));
    chk("refill_need", 32'(a_need), 32'h2);
    a_read(2'd0, 1'b0);
    chk("refill_rd0", 32'(a_rd_data), 32'hE0);
    a_read(2'd3, 1'b0);
    chk("refill_rd3", 32'(a_rd_data), 32'hE3);

    // Out-of-bounds read on FILL_LEN=3 instance
    for (int i = 0; i < 3; i++) b_write(8'hF0 + 8'(i));
    chk("b_fill_need",  32'(b_need),     32'h2);
    chk("b_rd_ready",   32'(b_rd_ready), 32'h1);
    chk("b_err_pre",    32'(b_err),      32'h0);
    b_read(2'd3);
    chk("b_err_set",    32'(b_err),      32'h1);
    b_read(2'd1);
    chk("b_good_data",  32'(b_rd_data),  32'hF1);
    chk("b_err_held",   32'(b_err),      32'h1);
    b_read(2'd2);
    chk("b_err_held2",  32'(b_err),      32'h1);
    chk("a_err_clear",  32'(a_err),      32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
